// File: rtl/ray_pixel_sequencer.sv
// ray_pixel_sequencer
//   Frame-level pixel/sample sequencer feeding the ray maker. Emits one
//   (pixel_h, pixel_v, sample_idx) tuple per valid/ready handshake, in raster
//   or tiled order, with spp consecutive samples per pixel. A frame is started
//   by a start pulse in IDLE. In continuous mode the next frame is re-armed
//   automatically after a single DONE cycle, and frame_id increments.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   start          begin a frame (only looked at in IDLE)
//   continuous     re-arm the next frame at each frame boundary
//   tiled          0 = raster order, 1 = tiled order (latched at frame start)
//   spp            samples per pixel (latched at frame start, 0 behaves as 1)
//   out_ready      downstream accepts the current tuple
//   out_valid      tuple and flags below are valid
//   pixel_h/v      pixel column / row
//   sample_idx     sample number within the pixel
//   last_sample    sample_idx is the last sample of the pixel
//   frame_last     last sample of the last pixel of the frame
//   frame_id       id of the frame being emitted
//   busy           sequencer not idle
//   frame_done     one-cycle pulse the cycle after the frame_last transfer
module ray_pixel_sequencer #(
    parameter int SIZE_H     = 1280,
    parameter int SIZE_V     = 720,
    parameter int TILE_H     = 16,
    parameter int TILE_V     = 16,
    parameter int SPP_W      = 4,
    parameter int FRAME_ID_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  tiled,
    input  logic [SPP_W-1:0]      spp,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [10:0]           pixel_h,
    output logic [9:0]            pixel_v,
    output logic [SPP_W-1:0]      sample_idx,
    output logic                  last_sample,
    output logic                  frame_last,
    output logic [FRAME_ID_W-1:0] frame_id,
    output logic                  busy,
    output logic                  frame_done
);

    localparam logic [10:0] H_LAST      = 11'(SIZE_H - 1);
    localparam logic [9:0]  V_LAST      = 10'(SIZE_V - 1);
    localparam logic [10:0] TILE_H_STEP = 11'(TILE_H);
    localparam logic [9:0]  TILE_V_STEP = 10'(TILE_V);
    localparam logic [10:0] LAST_TILE_X = 11'(SIZE_H - TILE_H);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic             tiled_l;
    logic [SPP_W-1:0] spp_l;
    logic [10:0]      tile_x;
    logic [9:0]       tile_y;

    logic [SPP_W-1:0] spp_start;
    logic [SPP_W-1:0] s_nxt;
    logic [10:0]      h_nxt, tx_nxt;
    logic [9:0]       v_nxt, ty_nxt;
    logic             pix_wrap;
    logic             ls_nxt;
    logic             load;

    // Next position after the current sample is accepted. Only consulted for
    // non-final transfers, so the counters never step past the frame edge.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        spp_start = (spp == '0) ? SPP_W'(1) : spp;
        load      = (state == IDLE && start) || (state == DONE && continuous);
        pix_wrap  = (sample_idx == spp_l - SPP_W'(1));
        s_nxt     = pix_wrap ? '0 : sample_idx + SPP_W'(1);
        h_nxt     = pixel_h;
        v_nxt     = pixel_v;
        tx_nxt    = tile_x;
        ty_nxt    = tile_y;
        if (pix_wrap) begin
            if (!tiled_l) begin
                if (pixel_h == H_LAST) begin
                    h_nxt = '0;
                    v_nxt = pixel_v + 10'd1;
                end else begin
                    h_nxt = pixel_h + 11'd1;
                end
            end else if (pixel_h != tile_x + TILE_H_STEP - 11'd1) begin
                h_nxt = pixel_h + 11'd1;
            end else if (pixel_v != tile_y + TILE_V_STEP - 10'd1) begin
                // next row of the same tile
                h_nxt = tile_x;
                v_nxt = pixel_v + 10'd1;
            end else if (tile_x != LAST_TILE_X) begin
                // next tile to the right
                tx_nxt = tile_x + TILE_H_STEP;
                h_nxt  = tx_nxt;
                v_nxt  = tile_y;
            end else begin
                // first tile of the next tile row
                tx_nxt = '0;
                ty_nxt = tile_y + TILE_V_STEP;
                h_nxt  = '0;
                v_nxt  = ty_nxt;
            end
        end
        ls_nxt = (s_nxt == spp_l - SPP_W'(1));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tiled_l     <= 1'b0;
            spp_l       <= SPP_W'(1);
            tile_x      <= '0;
            tile_y      <= '0;
            out_valid   <= 1'b0;
            pixel_h     <= '0;
            pixel_v     <= '0;
            sample_idx  <= '0;
            last_sample <= 1'b0;
            frame_last  <= 1'b0;
            frame_id    <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == DONE) begin
                frame_id <= frame_id + FRAME_ID_W'(1);
            end
            if (load) begin
                // Frame start: first sample is presented on the next cycle.
                state       <= RUN;
                busy        <= 1'b1;
                tiled_l     <= tiled;
                spp_l       <= spp_start;
                tile_x      <= '0;
                tile_y      <= '0;
                pixel_h     <= '0;
                pixel_v     <= '0;
                sample_idx  <= '0;
                last_sample <= (spp_start == SPP_W'(1));
                frame_last  <= 1'b0;
                out_valid   <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (out_valid && out_ready) begin
                            if (frame_last) begin
                                state       <= DONE;
                                out_valid   <= 1'b0;
                                last_sample <= 1'b0;
                                frame_last  <= 1'b0;
                                frame_done  <= 1'b1;
                            end else begin
                                sample_idx  <= s_nxt;
                                pixel_h     <= h_nxt;
                                pixel_v     <= v_nxt;
                                tile_x      <= tx_nxt;
                                tile_y      <= ty_nxt;
                                last_sample <= ls_nxt;
                                frame_last  <= ls_nxt && h_nxt == H_LAST && v_nxt == V_LAST;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ray_pixel_sequencer.sv
module tb_ray_pixel_sequencer;

    localparam int SH = 8;
    localparam int SV = 4;
    localparam int TH = 4;
    localparam int TV = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, continuous, tiled, out_ready;
    logic [3:0] spp;
    logic       out_valid, last_sample, frame_last, busy, frame_done;
    logic [10:0] pixel_h;
    logic [9:0]  pixel_v;
    logic [3:0]  sample_idx;
    logic [7:0]  frame_id;

    ray_pixel_sequencer #(
        .SIZE_H(SH), .SIZE_V(SV), .TILE_H(TH), .TILE_V(TV), .SPP_W(4), .FRAME_ID_W(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .tiled(tiled),
        .spp(spp), .out_ready(out_ready), .out_valid(out_valid), .pixel_h(pixel_h),
        .pixel_v(pixel_v), .sample_idx(sample_idx), .last_sample(last_sample),
        .frame_last(frame_last), .frame_id(frame_id), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int v;
        int s;
        bit ls;
        bit fl;
        int fid;
    } samp_t;

    samp_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    fid_m = 0;
    int    xfers = 0;
    int    done_cnt = 0;
    int    gaps = 0;
    bit    mon_en = 0;
    bit    stalled = 0;
    bit    fl_prev = 0;
    bit    seen_valid = 0;
    logic [63:0] held_vec = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference sequence: plain nested loops over the frame geometry.
    task automatic push_pixel(input int h, input int v, input int sl, input int fid);
        for (int s = 0; s < sl; s++) exp_q.push_back('{h, v, s, (s == sl - 1), 1'b0, fid});
    endtask

    task automatic push_frame(input bit tl, input int sp, input int fid);
        int sl;
        sl = (sp == 0) ? 1 : sp;
        if (!tl) begin
            for (int v = 0; v < SV; v++)
                for (int h = 0; h < SH; h++) push_pixel(h, v, sl, fid);
        end else begin
            for (int ty = 0; ty < SV; ty += TV)
                for (int tx = 0; tx < SH; tx += TH)
                    for (int y = 0; y < TV; y++)
                        for (int x = 0; x < TH; x++) push_pixel(tx + x, ty + y, sl, fid);
        end
        exp_q[exp_q.size() - 1].fl = 1'b1;
    endtask

    // Compare process: every handshake against the model, stall stability,
    // frame_done timing and inter-frame bubbles.
    always @(negedge clk) begin
        logic [63:0] cur;
        samp_t e;
        if (mon_en) begin
            cur = {28'd0, out_valid, pixel_h, pixel_v, sample_idx, last_sample, frame_last, frame_id};
            if (stalled) check("stall_hold", cur, held_vec);
            check("frame_done_timing", frame_done, fl_prev);
            fl_prev = out_valid && out_ready && frame_last;
            if (frame_done) done_cnt++;
            if (busy && !out_valid && seen_valid && exp_q.size() != 0) gaps++;
            if (out_valid) seen_valid = 1'b1;
            if (out_valid && out_ready) begin
                check("xfer_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("xfer_h", pixel_h, e.h);
                    check("xfer_v", pixel_v, e.v);
                    check("xfer_sample", sample_idx, e.s);
                    check("xfer_last_sample", last_sample, e.ls);
                    check("xfer_frame_last", frame_last, e.fl);
                    check("xfer_frame_id", frame_id, e.fid);
                end
                xfers++;
            end
            stalled  = out_valid && !out_ready;
            held_vec = cur;
        end
    end

    task automatic step(input bit rnd);
        @(posedge clk);
        #1;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse_start(input bit rnd);
        start = 1'b1;
        step(rnd);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input bit rnd);
        int n;
        n = 0;
        while ((done_cnt < target) && n < budget) begin
            step(rnd);
            n++;
        end
        check("frame_done_within_budget", (n < budget), 1);
    endtask

    task automatic run_one(input bit tl, input int sp, input bit rnd, input int n_exp);
        done_cnt = 0;
        xfers    = 0;
        push_frame(tl, sp, fid_m);
        tiled = tl;
        spp   = 4'(sp);
        pulse_start(rnd);
        // Inputs change mid-frame; the latched copies must govern.
        tiled = ~tl;
        spp   = 4'($urandom_range(0, 15));
        wait_done(1, 2000, rnd);
        fid_m = (fid_m + 1) % 256;
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
        check("idle_frame_id", frame_id, fid_m);
        check("xfer_count", xfers, n_exp);
        check("model_drained", exp_q.size(), 0);
        out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        tiled = 1'b0;
        spp = 4'd1;
        out_ready = 1'b1;
        #12;
        check("reset_state", {out_valid, busy, frame_done, last_sample, frame_last,
                              pixel_h, pixel_v, sample_idx, frame_id}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Hand-computed pins on the model itself.
        push_frame(1'b0, 1, 0);
        check("model_raster_len", exp_q.size(), 32);
        check("model_raster_8", {exp_q[8].h, exp_q[8].v}, {32'd0, 32'd1});
        exp_q.delete();
        push_frame(1'b1, 1, 0);
        check("model_tiled_4", {exp_q[4].h, exp_q[4].v}, {32'd0, 32'd1});
        check("model_tiled_8", {exp_q[8].h, exp_q[8].v}, {32'd4, 32'd0});
        check("model_tiled_16", {exp_q[16].h, exp_q[16].v}, {32'd0, 32'd2});
        check("model_tiled_end", {exp_q[31].h, exp_q[31].v, 31'd0, exp_q[31].fl}, {32'd7, 32'd3, 32'd1});
        exp_q.delete();
        push_frame(1'b0, 3, 0);
        check("model_spp3_len", exp_q.size(), 96);
        exp_q.delete();

        mon_en = 1'b1;
        step(0);

        run_one(1'b0, 1, 1'b0, 32);   // raster, spp 1
        run_one(1'b1, 1, 1'b0, 32);   // tiled
        run_one(1'b0, 3, 1'b0, 96);   // raster, 3 samples
        run_one(1'b0, 0, 1'b0, 32);   // spp 0 behaves as 1
        run_one(1'b0, 1, 1'b1, 32);   // backpressure
        run_one(1'b1, 2, 1'b1, 64);   // tiled, backpressure

        // Continuous: three frames back to back, stray start mid-frame.
        done_cnt = 0;
        xfers = 0;
        gaps = 0;
        seen_valid = 1'b0;
        for (int f = 0; f < 3; f++) push_frame(1'b0, 1, (fid_m + f) % 256);
        tiled = 1'b0;
        spp = 4'd1;
        continuous = 1'b1;
        pulse_start(0);
        for (int i = 0; i < 10; i++) step(0);
        pulse_start(0);
        wait_done(2, 2000, 0);
        continuous = 1'b0;
        wait_done(3, 2000, 0);
        fid_m = (fid_m + 3) % 256;
        check("cont_gaps", gaps, 2);
        check("cont_xfers", xfers, 96);
        check("cont_idle_busy", busy, 0);
        check("cont_frame_id", frame_id, fid_m);
        check("cont_model_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a frame.
        xfers = 0;
        push_frame(1'b0, 1, fid_m);
        pulse_start(0);
        for (int n = 0; n < 200 && xfers < 10; n++) step(0);
        check("reached_xfer_10", xfers, 10);
        mon_en = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset", {out_valid, busy, frame_id}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        fid_m = 0;
        stalled = 1'b0;
        fl_prev = 1'b0;
        mon_en = 1'b1;
        run_one(1'b0, 1, 1'b0, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
